// File: rtl/frag_base_serializer.sv
// rtl/frag_base_serializer.sv - fragment to base serializer feeding the proj_top base stream
module frag_base_serializer #(
    parameter int BASE_LEN = 2,
    parameter int FRAG_LEN = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAG_LEN-1:0] in_fragment,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wait,
    output logic [BASE_LEN-1:0] out_data,
    output logic                out_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    frag_sent
);

    localparam int NB    = FRAG_LEN / BASE_LEN;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state;
    logic [FRAG_LEN-1:0] shreg;
    logic [FRAG_LEN-1:0] hold;
    logic                hold_v;
    logic [IDX_W-1:0]    idx;

    logic                accept;
    logic                consume;
    logic                last_base;
    logic [FRAG_LEN-1:0] shifted;

    // Most-significant base of a fragment is the one transmitted first.
    function automatic logic [BASE_LEN-1:0] top_base(input logic [FRAG_LEN-1:0] f);
        return f[FRAG_LEN-1 -: BASE_LEN];
    endfunction

    // Handshake decode from registered state only; in_wait never reaches in_ready.
    assign in_ready  = !hold_v;
    assign busy      = (state == SEND) || hold_v;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && !in_wait;
    assign last_base = (idx == LAST_IDX);
    assign shifted   = shreg << BASE_LEN;

    // Serializer FSM: shift register, holding register, base index and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_v    <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frag_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= in_fragment;
                        out_data  <= top_base(in_fragment);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (consume && last_base) begin
                        frag_sent <= frag_sent + CNT_W'(1);
                        if (hold_v) begin
                            // Queued fragment moves straight into the shifter: no bubble.
                            shreg    <= hold;
                            out_data <= top_base(hold);
                            idx      <= '0;
                            if (accept) begin
                                hold <= in_fragment;
                            end else begin
                                hold_v <= 1'b0;
                            end
                        end else if (accept) begin
                            // Fragment arriving exactly at the handoff bypasses hold.
                            shreg    <= in_fragment;
                            out_data <= top_base(in_fragment);
                            idx      <= '0;
                        end else begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (consume) begin
                            shreg    <= shifted;
                            out_data <= top_base(shifted);
                            idx      <= idx + IDX_W'(1);
                        end
                        if (accept) begin
                            hold   <= in_fragment;
                            hold_v <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frag_base_serializer.sv
// tb/tb_frag_base_serializer.sv - self-checking bench for frag_base_serializer
module tb_frag_base_serializer;

    localparam int BL = 2;
    localparam int FL = 8;
    localparam int CW = 4;
    localparam int NB = FL / BL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FL-1:0] in_fragment = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_wait = 1'b0;
    logic [BL-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] frag_sent;

    int nvec = 0;
    int nerr = 0;

    frag_base_serializer #(.BASE_LEN(BL), .FRAG_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_fragment(in_fragment), .in_valid(in_valid),
        .in_ready(in_ready), .in_wait(in_wait), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .frag_sent(frag_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [FL-1:0] frag;
        logic          wt;
        logic          eov;
        logic [BL-1:0] eod;
        logic          eir;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_wait  = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            in_valid    = tbl[i].iv;
            in_fragment = tbl[i].frag;
            in_wait     = tbl[i].wt;
            step();
            chk({name, "_ov"}, 32'(out_valid), 32'(tbl[i].eov));
            chk({name, "_od"}, 32'(out_data), 32'(tbl[i].eod));
            chk({name, "_ir"}, 32'(in_ready), 32'(tbl[i].eir));
        end
        in_valid = 1'b0;
        in_wait  = 1'b0;
    endtask

    vec_t t2[$];
    vec_t t3[$];

    initial begin
        logic [FL-1:0] frags4 [3];
        logic [BL-1:0] got[$];
        int            acc_cyc[$];
        logic [BL-1:0] q[$];
        int            bases_done;
        logic [CW-1:0] m_sent;
        int            k;
        int            resident;
        logic          acc;
        logic          cons;
        logic          gap;
        int            cnt;

        // Test 2: single fragment, no stall.
        t2.push_back('{1'b1, 8'hB4, 1'b0, 1'b1, 2'd2, 1'b1});
        t2.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1});
        t2.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1});
        t2.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1});
        t2.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});
        // Test 3: stall for 3 cycles while the 2nd base is shown.
        t3.push_back('{1'b1, 8'hB4, 1'b0, 1'b1, 2'd2, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1});
        t3.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});

        // Test 1: reset values held for 3 idle cycles after release.
        #1;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_ir", 32'(in_ready), 1);
        chk("rst_fs", 32'(frag_sent), 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ov", 32'(out_valid), 0);
            chk("idle_od", 32'(out_data), 0);
            chk("idle_ir", 32'(in_ready), 1);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_fs", 32'(frag_sent), 0);
        end

        run_table("single", t2);
        chk("single_fs", 32'(frag_sent), 1);
        chk("single_busy", 32'(busy), 0);

        do_reset();
        run_table("stall", t3);
        chk("stall_fs", 32'(frag_sent), 1);

        // Test 4: back-to-back fragments with in_valid held high.
        do_reset();
        frags4[0] = 8'h1B;
        frags4[1] = 8'hE4;
        frags4[2] = 8'hFF;
        k   = 0;
        gap = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid    = (k < 3);
            in_fragment = (k < 3) ? frags4[k] : '0;
            acc         = in_valid && in_ready;
            if (acc) acc_cyc.push_back(c);
            step();
            if (acc) k++;
            if (out_valid) got.push_back(out_data);
            else if (got.size() > 0 && got.size() < 12) gap = 1'b1;
        end
        in_valid = 1'b0;
        chk("b2b_gap", 32'(gap), 0);
        chk("b2b_len", 32'(got.size()), 12);
        for (int i = 0; i < 12; i++) begin
            logic [FL-1:0] f;
            f = frags4[i / NB];
            chk("b2b_base", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(f[FL-1-(i%NB)*BL -: BL]));
        end
        chk("b2b_nacc", 32'(acc_cyc.size()), 3);
        chk("b2b_acc1", (acc_cyc.size() > 1) ? 32'(acc_cyc[1]) : 32'hFFFF, 1);
        chk("b2b_acc2", (acc_cyc.size() > 2) ? 32'(acc_cyc[2]) : 32'hFFFF, 5);
        chk("b2b_fs", 32'(frag_sent), 3);

        // Test 5: asynchronous reset with a fragment in flight and hold full.
        do_reset();
        in_valid = 1'b1; in_fragment = 8'hB4;
        step();
        in_fragment = 8'h55;
        step();
        in_valid = 1'b0;
        chk("ar_pre_od", 32'(out_data), 3);
        chk("ar_pre_ir", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", 32'(out_valid), 0);
        chk("ar_od", 32'(out_data), 0);
        chk("ar_ir", 32'(in_ready), 1);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_fs", 32'(frag_sent), 0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("ar_nobase", 32'(cnt), 0);
        chk("ar_fs2", 32'(frag_sent), 0);

        // Test 6: counter wraps after 2^CW+1 fragments.
        do_reset();
        k = 0;
        for (int c = 0; c < 500 && k < 17; c++) begin
            in_valid    = 1'b1;
            in_fragment = 8'(k);
            acc         = in_ready;
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 200) begin
            step();
            cnt++;
        end
        chk("wrap_acc", 32'(k), 17);
        chk("wrap_drain", 32'(busy), 0);
        chk("wrap_fs", 32'(frag_sent), 1);

        // Random traffic against a base-queue model.
        do_reset();
        q.delete();
        bases_done = 0;
        m_sent     = '0;
        for (int c = 0; c < 800; c++) begin
            resident = (q.size() + NB - 1) / NB;
            chk("rnd_ov", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_od", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 0);
            chk("rnd_ir", 32'(in_ready), 32'(resident < 2));
            chk("rnd_busy", 32'(busy), 32'(resident > 0));
            chk("rnd_fs", 32'(frag_sent), 32'(m_sent));
            in_valid    = ($urandom_range(0, 2) != 0);
            in_fragment = FL'($urandom);
            in_wait     = ($urandom_range(0, 3) == 0);
            acc  = in_valid && (resident < 2);
            cons = (q.size() > 0) && !in_wait;
            step();
            if (cons) begin
                void'(q.pop_front());
                bases_done++;
                if (bases_done == NB) begin
                    bases_done = 0;
                    m_sent++;
                end
            end
            if (acc) begin
                for (int b = 0; b < NB; b++) q.push_back(in_fragment[FL-1-b*BL -: BL]);
            end
        end
        in_valid = 1'b0;
        in_wait  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
